jump_engine: RTL

Parametrised charge-and-jump engine for the jump game: debounces the raw press button, converts press duration into a jump length, animates the squat while charging, and then animates a parabolic jump arc frame by frame on the shared animation `pulse`. It replaces the separate debounce, charge and jump-trajectory logic with one block. It adds a selectable ping-pong charge mode and configurable arc height and frame count. It sits between the game control FSM, which drives `arm` and consumes `jump_fin`, and the VGA display, which consumes `man_x`, `man_y` and `man_tall`.

---
 rtl/jump_engine_if.sv | 28 ++
 rtl/jump_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jump_engine_if.sv
// Bundle of the jump engine's game-side signals: control-FSM handshake,
// raw button, take-off coordinates and the display-facing figure outputs.
interface jump_engine_if #(
  parameter int unsigned W = 10
);
  logic         pulse;
  logic         press;
  logic         arm;
  logic         mode;
  logic [W-1:0] start_x;
  logic [W-1:0] base_y;
  logic [W-1:0] man_x;
  logic [W-1:0] man_y;
  logic [W-1:0] man_tall;
  logic [W-1:0] length;
  logic         jump_fin;
  logic [2:0]   state;

  modport master (
    output pulse, press, arm, mode, start_x, base_y,
    input  man_x, man_y, man_tall, length, jump_fin, state
  );

  modport slave (
    input  pulse, press, arm, mode, start_x, base_y,
    output man_x, man_y, man_tall, length, jump_fin, state
  );
endinterface

// File: rtl/jump_engine.sv
// Charge-and-jump engine: debounces the button, charges a jump length while
// squatting the figure, then plays an N-frame parabolic arc on the animation pulse.
module jump_engine #(
  parameter int unsigned W            = 10,
  parameter int unsigned DEBOUNCE     = 8,
  parameter int unsigned CHARGE_MAX   = 400,
  parameter int unsigned CHARGE_STEP  = 2,
  parameter int unsigned TALL         = 40,
  parameter int unsigned SQUASH_SHIFT = 4,
  parameter int unsigned SQUASH_MAX   = 20,
  parameter int unsigned STEPS_LOG2   = 5,
  parameter int unsigned ARC_H        = 64
) (
  input logic         clk,
  input logic         rst,
  jump_engine_if.slave bus
);

  localparam int unsigned N  = 1 << STEPS_LOG2;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned SW = STEPS_LOG2 + 1;
  localparam int unsigned XW = W + STEPS_LOG2 + 2;
  localparam int unsigned AW = $clog2(ARC_H + 1);
  localparam int unsigned HW = 2 * STEPS_LOG2 + AW + 3;
  localparam int unsigned YW = (HW > W) ? HW : W;

  localparam logic [CW-1:0] DEB_C   = CW'(DEBOUNCE);
  localparam logic [W-1:0]  TALL_W  = W'(TALL);
  localparam logic [W-1:0]  STEP_W  = W'(CHARGE_STEP);
  localparam logic [W-1:0]  MAX_W   = W'(CHARGE_MAX);
  localparam logic [W:0]    MAX_W1  = (W + 1)'(CHARGE_MAX);
  localparam logic [W-1:0]  SQMAX_W = W'(SQUASH_MAX);
  localparam logic [SW-1:0] N_S     = SW'(N);
  localparam logic [XW-1:0] XSAT    = XW'({W{1'b1}});
  localparam logic [HW-1:0] ARC4    = HW'(4 * ARC_H);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_CHARGE = 3'd2,
    S_FLIGHT = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          clean_prev_q;
  logic [W-1:0]  man_x_q, man_y_q, man_tall_q, length_q;
  logic [W-1:0]  start_q, base_q;
  logic          jump_fin_q;
  logic [SW-1:0] step_q;
  logic          dir_q;
  logic          charge_mode_q;

  logic          press_clean_s;
  logic          clean_rise_s;
  logic [W:0]    up_sum_s;
  logic [W-1:0]  len_d;
  logic          dir_d;
  logic [W-1:0]  squash_s;
  logic [W-1:0]  tall_d;
  logic [SW-1:0] step_n_s;
  logic [XW-1:0] x_prod_s, x_sum_s, land_sum_s;
  logic [W-1:0]  x_d, land_x_d;
  logic [HW-1:0] h_prod_s;
  logic [YW-1:0] h_s, base_ext_s;
  logic [W-1:0]  y_d;

  assign press_clean_s = (cnt_q == DEB_C);
  assign clean_rise_s  = press_clean_s && !clean_prev_q;

  // Debounce counter and the delayed clean level used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      clean_prev_q <= 1'b0;
    end else begin
      if (!bus.press) begin
        cnt_q <= '0;
      end else if (cnt_q != DEB_C) begin
        cnt_q <= cnt_q + 1'b1;
      end
      clean_prev_q <= press_clean_s;
    end
  end

  // Next charge length and direction; direction 1 means counting down (ping-pong only)
  always_comb begin
    up_sum_s = {1'b0, length_q} + {1'b0, STEP_W};
    len_d    = length_q;
    dir_d    = dir_q;
    if (charge_mode_q && dir_q) begin
      if (length_q <= STEP_W) begin
        len_d = '0;
        dir_d = 1'b0;
      end else begin
        len_d = length_q - STEP_W;
        dir_d = 1'b1;
      end
    end else begin
      if (up_sum_s >= MAX_W1) begin
        len_d = MAX_W;
        dir_d = charge_mode_q;
      end else begin
        len_d = up_sum_s[W-1:0];
        dir_d = 1'b0;
      end
    end
    squash_s = len_d >> SQUASH_SHIFT;
    if (squash_s > SQMAX_W) begin
      tall_d = TALL_W - SQMAX_W;
    end else begin
      tall_d = TALL_W - squash_s;
    end
  end

  // Arc frame for the upcoming step: linear x progress, parabolic height
  always_comb begin
    step_n_s   = step_q + 1'b1;
    x_prod_s   = XW'(length_q) * XW'(step_n_s);
    x_sum_s    = XW'(start_q) + (x_prod_s >> STEPS_LOG2);
    land_sum_s = XW'(start_q) + XW'(length_q);
    if (x_sum_s > XSAT) begin
      x_d = {W{1'b1}};
    end else begin
      x_d = x_sum_s[W-1:0];
    end
    if (land_sum_s > XSAT) begin
      land_x_d = {W{1'b1}};
    end else begin
      land_x_d = land_sum_s[W-1:0];
    end
    h_prod_s   = ARC4 * HW'(step_n_s) * HW'(N_S - step_n_s);
    h_s        = YW'(h_prod_s >> (2 * STEPS_LOG2));
    base_ext_s = YW'(base_q);
    if (base_ext_s > h_s) begin
      y_d = W'(base_ext_s - h_s);
    end else begin
      y_d = '0;
    end
  end

  // Main FSM with all figure outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      man_x_q       <= '0;
      man_y_q       <= '0;
      man_tall_q    <= TALL_W;
      length_q      <= '0;
      jump_fin_q    <= 1'b0;
      step_q        <= '0;
      dir_q         <= 1'b0;
      charge_mode_q <= 1'b0;
      start_q       <= '0;
      base_q        <= '0;
    end else begin
      jump_fin_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            start_q    <= bus.start_x;
            base_q     <= bus.base_y;
            man_x_q    <= bus.start_x;
            man_y_q    <= bus.base_y;
            length_q   <= '0;
            man_tall_q <= TALL_W;
            state_q    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (clean_rise_s) begin
            charge_mode_q <= bus.mode;
            dir_q         <= 1'b0;
            state_q       <= S_CHARGE;
          end else if (!bus.arm) begin
            state_q <= S_IDLE;
          end
        end
        S_CHARGE: begin
          // Release has priority over a coincident pulse
          if (!press_clean_s) begin
            step_q     <= '0;
            man_tall_q <= TALL_W;
            state_q    <= S_FLIGHT;
          end else if (bus.pulse) begin
            length_q   <= len_d;
            dir_q      <= dir_d;
            man_tall_q <= tall_d;
          end
        end
        S_FLIGHT: begin
          if (bus.pulse) begin
            step_q <= step_n_s;
            if (step_n_s == N_S) begin
              man_x_q    <= land_x_d;
              man_y_q    <= base_q;
              jump_fin_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              man_x_q <= x_d;
              man_y_q <= y_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.man_x    = man_x_q;
  assign bus.man_y    = man_y_q;
  assign bus.man_tall = man_tall_q;
  assign bus.length   = length_q;
  assign bus.jump_fin = jump_fin_q;
  assign bus.state    = state_q;

endmodule
